// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
//   Four-requester round-robin arbiter. Each granted frame samples
//   FRAME_LEN serial bits from the winner's d_in lane and runs a Moore
//   "101" detector on them, counting matches (saturating at 15).
//
// Parameters
//   FRAME_LEN   samples per granted frame (2..255)
//
// Build option
//   SEQ_DET_OVERLAP_EN  when defined, S101 -0-> S10 (overlapping detection);
//                       otherwise S101 -0-> S0.
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   req[3:0]    level-sensitive frame requests
//   d_in[3:0]   serial data, bit i belongs to requester i
//   gnt[3:0]    one-hot grant (or zero)
//   busy        high while a frame is in progress
//   q_out       "101" detect flag of the granted stream
//   frame_done  one-cycle pulse on frame completion
//   match_id    index of the completed requester (valid with frame_done)
//   match_cnt   saturating match count of the frame (valid with frame_done)
module seq_det_arbiter #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] d_in,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       q_out,
  output logic       frame_done,
  output logic [1:0] match_id,
  output logic [3:0] match_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

  state_t     r_state;
  det_t       r_det;
  logic [3:0] r_gnt;
  logic [1:0] r_winner;
  logic [1:0] r_last;
  logic [7:0] r_bitcnt;
  logic [3:0] r_match_cnt;
  logic [1:0] r_match_id;

  state_t     w_state_nxt;
  det_t       w_det_adv;
  logic [1:0] w_rr_win;
  logic       w_rr_hit;
  logic       w_bit;
  logic       w_last_sample;
  logic       w_abort;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    w_rr_win = '0;
    w_rr_hit = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!w_rr_hit && req[r_last + 2'(i)]) begin
        w_rr_hit = 1'b1;
        w_rr_win = r_last + 2'(i);
      end
    end
  end

  // Detector advance for the current sample of the winner's lane.
  always_comb begin
    w_bit     = d_in[r_winner];
    w_det_adv = S0;
    case (r_det)
      S0:   w_det_adv = w_bit ? S1 : S0;
      S1:   w_det_adv = w_bit ? S1 : S10;
      S10:  w_det_adv = w_bit ? S101 : S0;
      S101: begin
`ifdef SEQ_DET_OVERLAP_EN
        w_det_adv = w_bit ? S1 : S10;
`else
        w_det_adv = w_bit ? S1 : S0;
`endif
      end
      default: w_det_adv = S0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_sample = (r_bitcnt == 8'(FRAME_LEN - 1));
    w_abort       = !req[r_winner];
    case (r_state)
      IDLE:    if (w_rr_hit) w_state_nxt = GRANT;
      GRANT: begin
        if (w_abort)            w_state_nxt = IDLE;
        else if (w_last_sample) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_det       <= S0;
      r_gnt       <= '0;
      r_winner    <= '0;
      r_last      <= 2'd3;
      r_bitcnt    <= '0;
      r_match_cnt <= '0;
      r_match_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_rr_hit) begin
            r_gnt       <= 4'b0001 << w_rr_win;
            r_winner    <= w_rr_win;
            r_last      <= w_rr_win;
            r_bitcnt    <= '0;
            r_match_cnt <= '0;
            r_det       <= S0;
          end
        end
        GRANT: begin
          if (w_abort) begin
            r_gnt       <= '0;
            r_det       <= S0;
            r_bitcnt    <= '0;
            r_match_cnt <= '0;
          end else begin
            r_bitcnt <= r_bitcnt + 8'd1;
            if (w_det_adv == S101 && r_match_cnt != '1)
              r_match_cnt <= r_match_cnt + 4'd1;
            // Final sample still counts its match, but the detector drops
            // straight to S0 so q_out stays low outside GRANT.
            if (w_last_sample) begin
              r_det      <= S0;
              r_gnt      <= '0;
              r_match_id <= r_winner;
            end else begin
              r_det <= w_det_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign busy       = (r_state == GRANT);
  assign q_out      = (r_det == S101);
  assign frame_done = (r_state == DONE);
  assign match_id   = r_match_id;
  assign match_cnt  = r_match_cnt;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Self-checking bench for seq_det_arbiter: directed steps plus randomized
// frames, checked against a frame-level reference model (round-robin pick
// and "101" substring counting over the sampled bit list).
module tb_seq_det_arbiter;

  localparam int unsigned FL = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] d_in;

  logic [3:0] gnt, match_cnt;
  logic       busy, q_out, frame_done;
  logic [1:0] match_id;

  logic [3:0] gnt64, match_cnt64;
  logic       busy64, q_out64, frame_done64;
  logic [1:0] match_id64;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int exp_last = 3;

  always #5 clk = ~clk;

  seq_det_arbiter #(.FRAME_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .d_in(d_in),
    .gnt(gnt), .busy(busy), .q_out(q_out), .frame_done(frame_done),
    .match_id(match_id), .match_cnt(match_cnt)
  );

  seq_det_arbiter #(.FRAME_LEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .req(req), .d_in(d_in),
    .gnt(gnt64), .busy(busy64), .q_out(q_out64), .frame_done(frame_done64),
    .match_id(match_id64), .match_cnt(match_cnt64)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int min15(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'hF;
    d_in    = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_q", q_out, 0);
      check("rst_done", frame_done, 0);
      check("rst_id", match_id, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_gnt64", gnt64, 0);
    end
    reset_n  = 1'b1;
    req      = '0;
    exp_last = 3;
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_frame(input logic [3:0] rq, input logic [15:0] pat,
                           input int abort_at, input bit hold);
    int w, cnt, last_end;
    logic [3:0] onehot;
    bit hit, aborted;
    w        = rr_pick(rq, exp_last);
    exp_last = w;
    onehot   = 4'b0001 << w;
    req      = rq;
    d_in     = 4'($urandom);
    @(negedge clk);
    check("entry_gnt", gnt, onehot);
    check("entry_busy", busy, 1);
    check("entry_cnt", match_cnt, 0);
    check("entry_q", q_out, 0);
    cnt = 0; last_end = -10; aborted = 0;
    for (int s = 0; s < int'(FL); s++) begin
      d_in    = 4'($urandom);
      d_in[w] = pat[s];
      req     = hold ? rq : (4'($urandom) | onehot);
      if (s == abort_at) req[w] = 1'b0;
      @(negedge clk);
      if (s == abort_at) begin
        aborted = 1;
        check("abort_gnt", gnt, 0);
        check("abort_busy", busy, 0);
        check("abort_done", frame_done, 0);
        check("abort_cnt", match_cnt, 0);
        check("abort_q", q_out, 0);
        break;
      end
      hit = 0;
      if (s >= 2 && pat[s-2] && !pat[s-1] && pat[s]) begin
`ifdef SEQ_DET_OVERLAP_EN
        hit = 1;
`else
        hit = (s - 2 > last_end);
`endif
      end
      if (hit) begin
        cnt++;
        last_end = s;
      end
      if (s < int'(FL) - 1) begin
        check("run_gnt", gnt, onehot);
        check("run_busy", busy, 1);
        check("run_q", q_out, hit);
        check("run_cnt", match_cnt, min15(cnt));
        check("run_done", frame_done, 0);
      end else begin
        check("done_pulse", frame_done, 1);
        check("done_id", match_id, w);
        check("done_cnt", match_cnt, min15(cnt));
        check("done_gnt", gnt, 0);
        check("done_busy", busy, 0);
        check("done_q", q_out, 0);
      end
    end
    if (!aborted) begin
      @(negedge clk);
      check("idle_done", frame_done, 0);
      check("idle_cnt_hold", match_cnt, min15(cnt));
      check("idle_busy", busy, 0);
      check("idle_gnt", gnt, 0);
    end
    if (!hold) req = '0;
  endtask

  initial begin
    logic [3:0] rq;
    int ab;
    bit bit_s;

    // Reset with all requests asserted.
    do_reset();

    // Directed 1,0,1,0,1 then zeros on requester 0.
    run_frame(4'b0001, 16'h0015, -1, 0);

    // All requesters held: 0,1,2,3,0 with DONE + IDLE between grants.
    do_reset();
    for (int i = 0; i < 5; i++) run_frame(4'hF, 16'($urandom), -1, (i != 4));

    // Requester 2 aborts after 5 samples while 3 waits; 3 wins next.
    run_frame(4'b1100, 16'($urandom), 5, 1);
    run_frame(4'b1000, 16'($urandom), -1, 0);

    // Randomized frames with occasional aborts and held requests.
    for (int i = 0; i < 12; i++) begin
      rq = 4'($urandom_range(1, 15));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
      run_frame(rq, 16'($urandom), ab, 1'($urandom_range(0, 1)));
    end
    req = '0;

    // Reset in the middle of a frame.
    do_reset();
    req = 4'b0001;
    exp_last = rr_pick(req, exp_last);
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0001);
    for (int s = 0; s < 8; s++) begin
      d_in = 4'($urandom);
      @(negedge clk);
    end
    check("mid_busy_pre", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_cnt", match_cnt, 0);
    reset_n  = 1'b1;
    req      = '0;
    exp_last = 3;
    @(negedge clk);
    check("mid_post_done", frame_done, 0);
    check("mid_post_busy", busy, 0);
    run_frame(4'b0010, 16'($urandom), -1, 0);

    // FRAME_LEN=64 with "101" repeated: 21 raw matches, saturates at 15.
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    check("f64_gnt", gnt64, 4'b0001);
    for (int s = 0; s < 64; s++) begin
      bit_s = ((s % 3) != 1);
      d_in  = {3'($urandom), bit_s};
      @(negedge clk);
      if (s == 2)  begin check("f64_q", q_out64, 1); check("f64_cnt1", match_cnt64, 1); end
      if (s == 41) check("f64_cnt14", match_cnt64, 14);
      if (s == 44) check("f64_cnt15", match_cnt64, 15);
      if (s == 47) check("f64_sat", match_cnt64, 15);
      if (s == 62) check("f64_busy", busy64, 1);
      if (s == 63) begin
        check("f64_done", frame_done64, 1);
        check("f64_cnt_final", match_cnt64, 15);
        check("f64_id", match_id64, 0);
      end
    end
    req = '0;
    @(negedge clk);
    check("f64_idle_done", frame_done64, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
